// File: rtl/intellitec_pkg.sv
// Shared types and helpers for the Intellitec compressor guard: channel state
// encoding and the width rule used to size every tick-based timer.
package intellitec_pkg;

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    READY   = 2'd1,
    RUN_MIN = 2'd2,
    RUN     = 2'd3
  } comp_state_e;

  // Bits needed to hold 0..max_ticks, never less than one bit.
  function automatic int tick_width(input int max_ticks);
    return (max_ticks < 1) ? 1 : $clog2(max_ticks + 1);
  endfunction

endpackage

// File: rtl/intellitec_comp_channel.sv
// One compressor channel: 2-FF call synchroniser, tick-based debounce, and the
// anti-short-cycle state machine with its shared min-off/min-on timer.
module intellitec_comp_channel
  import intellitec_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 20,
  parameter int MIN_OFF_TICKS  = 180000,
  parameter int MIN_ON_TICKS   = 60000
) (
  input  logic clock,
  input  logic reset,
  input  logic tick_i,
  input  logic call_n_i,
  input  logic shed_i,
  input  logic grant_i,
  output logic start_req_o,
  output logic comp_on_o,
  output logic lockout_o
);

  localparam int DW = tick_width(DEBOUNCE_TICKS);
  localparam int TW = tick_width((MIN_OFF_TICKS > MIN_ON_TICKS) ? MIN_OFF_TICKS : MIN_ON_TICKS);
  localparam logic [DW-1:0] DEB_L     = DW'(DEBOUNCE_TICKS);
  localparam logic [TW-1:0] MIN_OFF_L = TW'(MIN_OFF_TICKS);
  localparam logic [TW-1:0] MIN_ON_L  = TW'(MIN_ON_TICKS);

  logic [1:0]    sync_q;
  logic          deb_n_q, deb_n_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d, deb_cnt_inc;
  comp_state_e   state_q, state_d;
  logic [TW-1:0] timer_q, timer_d, timer_dec;
  logic          comp_on_q, lockout_q;
  logic          call;

  assign call        = ~deb_n_q;
  assign deb_cnt_inc = deb_cnt_q + DW'(1);
  assign timer_dec   = (tick_i && (timer_q != '0)) ? timer_q - TW'(1) : timer_q;
  assign start_req_o = (state_q == READY) && call && !shed_i;
  assign comp_on_o   = comp_on_q;
  assign lockout_o   = lockout_q;

  // Debounce: count ticks while the synchronised call disagrees; any agreement restarts.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    deb_n_d   = deb_n_q;
    deb_cnt_d = '0;
    if (sync_q[1] != deb_n_q) begin
      deb_cnt_d = deb_cnt_q;
      if (tick_i) begin
        if (deb_cnt_inc >= DEB_L) begin
          deb_n_d   = sync_q[1];
          deb_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_inc;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_dec;
    unique case (state_q)
      LOCKOUT: if (timer_dec == '0) state_d = READY;
      READY: begin
        if (start_req_o && grant_i) begin
          state_d = RUN_MIN;
          timer_d = MIN_ON_L;
        end
      end
      RUN_MIN: begin
        // Shed overrides the min-on guarantee, even on the expiry tick.
        if (shed_i) begin
          state_d = LOCKOUT;
          timer_d = MIN_OFF_L;
        end else if (timer_dec == '0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (shed_i || !call) begin
          state_d = LOCKOUT;
          timer_d = MIN_OFF_L;
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q    <= 2'b11;
      deb_n_q   <= 1'b1;
      deb_cnt_q <= '0;
      state_q   <= LOCKOUT;
      timer_q   <= MIN_OFF_L;
      comp_on_q <= 1'b0;
      lockout_q <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      sync_q    <= {sync_q[0], call_n_i};
      deb_n_q   <= deb_n_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      comp_on_q <= (state_d == RUN_MIN) || (state_d == RUN);
      lockout_q <= (state_d == LOCKOUT);
    end
  end

endmodule

// File: rtl/intellitec_compressor_guard.sv
// Compressor relay guard: shared tick prescaler, start-stagger timer and a
// fixed-priority start arbiter (channel 1 first) over two protected channels.
module intellitec_compressor_guard
  import intellitec_pkg::*;
#(
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 20,
  parameter int MIN_OFF_TICKS  = 180000,
  parameter int MIN_ON_TICKS   = 60000,
  parameter int STAGGER_TICKS  = 5000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ac1_n,
  input  logic       ac2_n,
  input  logic [1:0] shed,
  output logic       comp1_on,
  output logic       comp2_on,
  output logic       comp1_lockout,
  output logic       comp2_lockout
);

  localparam int PW = tick_width(TICK_DIV - 1);
  localparam int SW = tick_width(STAGGER_TICKS);
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STAGGER_L = SW'(STAGGER_TICKS);

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] stag_q, stag_d;
  logic          tick;
  logic          req1, req2, grant1, grant2;

  assign tick   = (presc_q == '0);
  assign grant1 = req1 && (stag_q == '0);
  assign grant2 = req2 && (stag_q == '0) && !req1;

  always_comb begin
    presc_d = tick ? PRESC_MAX : presc_q - PW'(1);
    stag_d  = stag_q;
    if (grant1 || grant2) begin
      stag_d = STAGGER_L;
    end else if (tick && (stag_q != '0)) begin
      stag_d = stag_q - SW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      stag_q  <= '0;
    end else begin
      presc_q <= presc_d;
      stag_q  <= stag_d;
    end
  end

  intellitec_comp_channel #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .MIN_OFF_TICKS (MIN_OFF_TICKS),
    .MIN_ON_TICKS  (MIN_ON_TICKS)
  ) u_ch1 (
    .clock      (clock),
    .reset      (reset),
    .tick_i     (tick),
    .call_n_i   (ac1_n),
    .shed_i     (shed[0]),
    .grant_i    (grant1),
    .start_req_o(req1),
    .comp_on_o  (comp1_on),
    .lockout_o  (comp1_lockout)
  );

  intellitec_comp_channel #(
    .DEBOUNCE_TICKS(DEBOUNCE_TICKS),
    .MIN_OFF_TICKS (MIN_OFF_TICKS),
    .MIN_ON_TICKS  (MIN_ON_TICKS)
  ) u_ch2 (
    .clock      (clock),
    .reset      (reset),
    .tick_i     (tick),
    .call_n_i   (ac2_n),
    .shed_i     (shed[1]),
    .grant_i    (grant2),
    .start_req_o(req2),
    .comp_on_o  (comp2_on),
    .lockout_o  (comp2_lockout)
  );

endmodule

// File: tb/tb_intellitec_compressor_guard.sv
// Bench for intellitec_compressor_guard: hand-derived timing table, directed
// corner sequences, and random stimulus against a tick-timestamp reference model.
module tb_intellitec_compressor_guard;

  localparam int TICK_DIV = 4;
  localparam int DEB      = 2;
  localparam int MIN_OFF  = 10;
  localparam int MIN_ON   = 8;
  localparam int STAGGER  = 5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       ac1_n = 1'b0;
  logic       ac2_n = 1'b0;
  logic [1:0] shed  = 2'b00;
  logic       comp1_on, comp2_on, comp1_lockout, comp2_lockout;

  intellitec_compressor_guard #(
    .TICK_DIV      (TICK_DIV),
    .DEBOUNCE_TICKS(DEB),
    .MIN_OFF_TICKS (MIN_OFF),
    .MIN_ON_TICKS  (MIN_ON),
    .STAGGER_TICKS (STAGGER)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ac1_n        (ac1_n),
    .ac2_n        (ac2_n),
    .shed         (shed),
    .comp1_on     (comp1_on),
    .comp2_on     (comp2_on),
    .comp1_lockout(comp1_lockout),
    .comp2_lockout(comp2_lockout)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  // Outputs packed as {comp1_on, comp2_on, comp1_lockout, comp2_lockout}.
  function automatic logic [3:0] dut_out();
    return {comp1_on, comp2_on, comp1_lockout, comp2_lockout};
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got on=%b lockout=%b, expected on=%b lockout=%b",
               name, act[3:2], act[1:0], exp[3:2], exp[1:0]);
    end
  endtask

  // Reference model: timings are tracked as absolute tick indices, not down-counters.
  typedef enum int {M_LOCK, M_READY, M_RUN} m_phase_e;
  typedef struct {
    m_phase_e phase;
    int       end_ti;
    logic     deb_n;
    int       run_start;
    logic     dly1;
    logic     dly2;
  } m_chan_t;

  m_chan_t mc [2];
  int      k;
  int      last_start_ti;

  // Number of ticks that occurred at edges 0..e (edge 0 after reset is a tick).
  function automatic int ti_at(input int e);
    return (e < 0) ? 0 : e / TICK_DIV + 1;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mc[c].phase     = M_LOCK;
      mc[c].end_ti    = MIN_OFF;
      mc[c].deb_n     = 1'b1;
      mc[c].run_start = -1;
      mc[c].dly1      = 1'b1;
      mc[c].dly2      = 1'b1;
    end
    k             = 0;
    last_start_ti = -1;
  endtask

  task automatic model_edge(input logic a1, input logic a2, input logic [1:0] sh);
    bit   tk, ok;
    int   ti, tp;
    bit   call [2];
    bit   req [2];
    bit   grant [2];
    logic a [2];
    logic sync;
    a[0] = a1;
    a[1] = a2;
    tk = (k % TICK_DIV) == 0;
    ti = ti_at(k);
    tp = ti_at(k - 1);
    for (int c = 0; c < 2; c++) begin
      call[c] = (mc[c].deb_n == 1'b0);
      req[c]  = (mc[c].phase == M_READY) && call[c] && !sh[c];
    end
    ok       = (last_start_ti < 0) || (tp >= last_start_ti + STAGGER);
    grant[0] = req[0] && ok;
    grant[1] = req[1] && ok && !req[0];
    for (int c = 0; c < 2; c++) begin
      case (mc[c].phase)
        M_LOCK: if (tk && ti >= mc[c].end_ti) mc[c].phase = M_READY;
        M_READY: begin
          if (grant[c]) begin
            mc[c].phase   = M_RUN;
            mc[c].end_ti  = ti + MIN_ON;
            last_start_ti = ti;
          end
        end
        default: begin
          if (sh[c] || (tp >= mc[c].end_ti && !call[c])) begin
            mc[c].phase  = M_LOCK;
            mc[c].end_ti = ti + MIN_OFF;
          end
        end
      endcase
      sync = mc[c].dly2;
      if (sync == mc[c].deb_n) begin
        mc[c].run_start = -1;
      end else begin
        if (mc[c].run_start < 0) mc[c].run_start = k;
        if (tk && (ti - ti_at(mc[c].run_start - 1)) >= DEB) begin
          mc[c].deb_n     = sync;
          mc[c].run_start = -1;
        end
      end
      mc[c].dly2 = mc[c].dly1;
      mc[c].dly1 = a[c];
    end
    k++;
  endtask

  function automatic logic [3:0] model_out();
    return {mc[0].phase == M_RUN, mc[1].phase == M_RUN,
            mc[0].phase == M_LOCK, mc[1].phase == M_LOCK};
  endfunction

  // One clock: model follows the edge, DUT is compared on the falling edge.
  task automatic step();
    @(posedge clock);
    model_edge(ac1_n, ac2_n, shed);
    @(negedge clock);
    check($sformatf("model_edge%0d", k - 1), dut_out(), model_out());
  endtask

  task automatic run_to(input int target);
    while (k < target) step();
  endtask

  // Called on a falling edge; asserts reset mid-cycle and checks the asynchronous drop.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1 check("async_reset", dut_out(), 4'b0011);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    int         adv;
    logic       a1;
    logic       a2;
    logic [1:0] sh;
    logic [3:0] exp;
    string      name;
  } vec_t;

  vec_t tbl [6];

  function automatic vec_t mk(input int adv, input logic a1, input logic a2,
                              input logic [1:0] sh, input logic [3:0] exp, input string name);
    vec_t v;
    v.adv = adv; v.a1 = a1; v.a2 = a2; v.sh = sh; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic apply_table();
    for (int i = 0; i < 6; i++) begin
      ac1_n = tbl[i].a1;
      ac2_n = tbl[i].a2;
      shed  = tbl[i].sh;
      repeat (tbl[i].adv) step();
      check(tbl[i].name, dut_out(), tbl[i].exp);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Both calls held from power-up: lockout 10 ticks, comp1 next clock, comp2 a full stagger later.
    tbl[0] = mk(0,  1'b0, 1'b0, 2'b00, 4'b0011, "powerup_state");
    tbl[1] = mk(36, 1'b0, 1'b0, 2'b00, 4'b0011, "lockout_36clk");
    tbl[2] = mk(1,  1'b0, 1'b0, 2'b00, 4'b0000, "ready_at_tick10");
    tbl[3] = mk(1,  1'b0, 1'b0, 2'b00, 4'b1000, "comp1_start");
    tbl[4] = mk(19, 1'b0, 1'b0, 2'b00, 4'b1000, "comp2_waits_stagger");
    tbl[5] = mk(1,  1'b0, 1'b0, 2'b00, 4'b1100, "comp2_start_20clk");

    #1 reset = 1'b1;
    #1 check("reset_state", dut_out(), 4'b0011);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    apply_table();

    // Short cycle, re-call during lockout, then shed.
    do_reset();
    run_to(49);
    ac1_n = 1'b1;
    run_to(69);
    check("min_on_holds", dut_out(), 4'b1100);
    step();
    check("short_cycle_stop", dut_out(), 4'b0110);
    ac1_n = 1'b0;
    run_to(100);
    check("recall_locked", dut_out(), 4'b0110);
    run_to(109);
    check("ready_no_start_yet", dut_out(), 4'b0100);
    step();
    check("restart_after_min_off", dut_out(), 4'b1100);
    run_to(112);
    shed = 2'b01;
    step();
    check("shed_stop_1clk", dut_out(), 4'b0110);
    run_to(160);
    check("shed_blocks_start", dut_out(), 4'b0100);
    shed = 2'b00;
    step();
    check("start_after_shed", dut_out(), 4'b1100);
    run_to(200);
    check("both_running", dut_out(), 4'b1100);

    // Reset while both run, then power-up timing must repeat.
    do_reset();
    apply_table();

    // One-tick glitch on ac2_n is filtered and leaves the stagger timer idle.
    ac1_n = 1'b1;
    ac2_n = 1'b1;
    do_reset();
    run_to(40);
    ac2_n = 1'b0;
    run_to(44);
    ac2_n = 1'b1;
    run_to(61);
    check("glitch_ignored", dut_out(), 4'b0000);
    ac1_n = 1'b0;
    run_to(69);
    check("comp1_debouncing", dut_out(), 4'b0000);
    step();
    check("comp1_no_stagger_wait", dut_out(), 4'b1000);

    // Random calls, glitches and shed against the reference model.
    ac1_n = 1'($urandom_range(0, 1));
    ac2_n = 1'($urandom_range(0, 1));
    shed  = 2'b00;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 59) == 0) ac1_n = ~ac1_n;
      if ($urandom_range(0, 59) == 0) ac2_n = ~ac2_n;
      if ($urandom_range(0, 149) == 0) shed[0] = ~shed[0];
      if ($urandom_range(0, 149) == 0) shed[1] = ~shed[1];
      if (i == 2000) do_reset();
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
